// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite bus encodings shared by the responder and its bench.
// Transfer types, transfer sizes and response codes.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HWORD = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;
   localparam logic [2:0] HSIZE_B128  = 3'd4;
   localparam logic [2:0] HSIZE_B256  = 3'd5;
   localparam logic [2:0] HSIZE_B512  = 3'd6;
   localparam logic [2:0] HSIZE_B1024 = 3'd7;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   function automatic logic is_xfer(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb3lite_mem_slave_be.sv
// Byte-lane decode: transfer size and address LSBs to lane enables,
// plus a flag for addresses not aligned to the transfer size.
module ahb3lite_mem_slave_be
   import ahb3lite_pkg::*;
#(
   parameter int LANES = 4,
   parameter int LSB_W = 2
) (
   input  logic [2:0]       size,
   input  logic [LSB_W-1:0] lsb,
   output logic [LANES-1:0] be,
   output logic             misalign
);

   logic [LSB_W-1:0] mask;

   always_comb begin
      mask     = LSB_W'((32'd1 << size) - 32'd1);
      misalign = |(lsb & mask);
      be       = '0;
      for (int i = 0; i < LANES; i++) begin
         be[i] = (i >= int'(lsb)) && (i < int'(lsb) + (1 << size));
      end
   end

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite word memory responder with fixed wait states
// and the two-cycle ERROR response.
module ahb3lite_mem_slave
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE  = 16,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int LANES = HDATA_SIZE / 8;
   localparam int BW    = $clog2(LANES);
   localparam int LSB_W = (BW > 0) ? BW : 1;
   localparam int IW    = $clog2(MEM_DEPTH);

   localparam logic [2:0]            MAX_SIZE = 3'(BW);
   localparam logic [HADDR_SIZE-1:0] DEPTH_A  = HADDR_SIZE'(MEM_DEPTH);
   localparam logic [3:0]            WS       = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                  state;
   logic [3:0]              wcnt;
   logic [IW-1:0]           idx_q;
   logic                    we_q;
   logic [LANES-1:0]        be_q;
   logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

   logic [HADDR_SIZE-1:0]   word_a;
   logic [LSB_W-1:0]        lsb;
   logic [LANES-1:0]        be;
   logic                    misalign;
   logic                    accept;
   logic                    err;
   logic                    unused_ok;

   assign word_a = HADDR >> BW;
   assign lsb    = (BW > 0) ? HADDR[LSB_W-1:0] : '0;
   assign accept = HSEL & HREADY & is_xfer(HTRANS);
   assign err    = (HSIZE > MAX_SIZE) | misalign | (word_a >= DEPTH_A);

   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

   ahb3lite_mem_slave_be #(
      .LANES (LANES),
      .LSB_W (LSB_W)
   ) u_be (
      .size     (HSIZE),
      .lsb      (lsb),
      .be       (be),
      .misalign (misalign)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         wcnt      <= '0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
      end else begin
         unique case (state)
            ST_WAIT: begin
               if (wcnt == 4'd1) begin
                  state     <= ST_DATA;
                  HREADYOUT <= 1'b1;
                  wcnt      <= '0;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_ERROR;
            end
            ST_IDLE, ST_DATA, ST_ERR2: begin
               // data phase ends here, so the next address phase is live
               if (accept) begin
                  idx_q <= word_a[IW-1:0];
                  be_q  <= be;
                  if (err) begin
                     state     <= ST_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= HRESP_ERROR;
                     we_q      <= 1'b0;
                  end else if (WS != 4'd0) begin
                     state     <= ST_WAIT;
                     HREADYOUT <= 1'b0;
                     HRESP     <= HRESP_OKAY;
                     wcnt      <= WS;
                     we_q      <= HWRITE;
                  end else begin
                     state     <= ST_DATA;
                     HREADYOUT <= 1'b1;
                     HRESP     <= HRESP_OKAY;
                     we_q      <= HWRITE;
                  end
               end else begin
                  state     <= ST_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= HRESP_OKAY;
                  we_q      <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (state == ST_DATA && we_q) begin
         for (int i = 0; i < LANES; i++) begin
            if (be_q[i]) mem[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
         end
      end
   end

   assign HRDATA = (state == ST_DATA && !we_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench: zero-wait and three-wait responders on one master,
// checking data, wait timing, errors, bursts and reset.
module tb_ahb3lite_mem_slave;
   import ahb3lite_pkg::*;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        sel = 1'b1;
   logic        use3 = 1'b0;
   logic        hsel0, hsel3;
   logic [15:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = HSIZE_WORD;
   logic [2:0]  hburst = 3'b000;
   logic [3:0]  hprot = 4'b0011;
   logic [1:0]  htrans = HTRANS_IDLE;
   logic        hmastlock = 1'b0;
   logic        hready;
   logic [31:0] rdata0, rdata3;
   logic        ready0, ready3, resp0, resp3;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   assign hsel0  = sel & ~use3;
   assign hsel3  = sel & use3;
   assign hready = use3 ? ready3 : ready0;

   always #5 hclk = ~hclk;

   ahb3lite_mem_slave #(.WAIT_STATES(0)) u0 (
      .HCLK (hclk), .HRESET (hreset), .HSEL (hsel0),
      .HADDR (haddr), .HWDATA (hwdata), .HRDATA (rdata0),
      .HWRITE (hwrite), .HSIZE (hsize), .HBURST (hburst),
      .HPROT (hprot), .HTRANS (htrans), .HMASTLOCK (hmastlock),
      .HREADY (hready), .HREADYOUT (ready0), .HRESP (resp0)
   );

   ahb3lite_mem_slave #(.WAIT_STATES(3)) u3 (
      .HCLK (hclk), .HRESET (hreset), .HSEL (hsel3),
      .HADDR (haddr), .HWDATA (hwdata), .HRDATA (rdata3),
      .HWRITE (hwrite), .HSIZE (hsize), .HBURST (hburst),
      .HPROT (hprot), .HTRANS (htrans), .HMASTLOCK (hmastlock),
      .HREADY (hready), .HREADYOUT (ready3), .HRESP (resp3)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic ap(input logic [1:0] tr, input logic [15:0] a,
                     input logic w, input logic [2:0] sz);
      htrans = tr;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
   endtask

   task automatic count_waits(output int cnt);
      cnt = 0;
      while (hready == 1'b0 && cnt < 20) begin
         cnt++;
         tick();
      end
   endtask

   task automatic err_case(input string tag, input logic [15:0] a,
                           input logic [2:0] sz);
      ap(HTRANS_NONSEQ, a, 1'b1, sz);
      tick();
      chk({tag, "_e1_resp"}, resp0, 1);
      chk({tag, "_e1_rdy"}, ready0, 0);
      hwdata = 32'hFFFF_FFFF;
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      tick();
      chk({tag, "_e2_resp"}, resp0, 1);
      chk({tag, "_e2_rdy"}, ready0, 1);
      tick();
      chk({tag, "_after_resp"}, resp0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      chk("rst_rdy0", ready0, 1);
      chk("rst_resp0", resp0, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdy3", ready3, 1);
      hreset = 1'b0;
      tick();

      // zero-wait write then back-to-back read
      ap(HTRANS_NONSEQ, 16'h0010, 1'b1, HSIZE_WORD);
      tick();
      chk("w0_rdy", ready0, 1);
      hwdata = 32'hDEAD_BEEF;
      ap(HTRANS_NONSEQ, 16'h0010, 1'b0, HSIZE_WORD);
      tick();
      chk("r0_rdy", ready0, 1);
      chk("r0_data", rdata0, 32'hDEAD_BEEF);
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      tick();
      chk("idle_rdy", ready0, 1);
      chk("idle_rdata", rdata0, 0);

      // byte write lane 3
      ap(HTRANS_NONSEQ, 16'h0013, 1'b1, HSIZE_BYTE);
      tick();
      hwdata = 32'hA511_2233;
      ap(HTRANS_NONSEQ, 16'h0010, 1'b0, HSIZE_WORD);
      tick();
      chk("byte_rd", rdata0, 32'hA5AD_BEEF);
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      tick();

      // unselected write must not land
      sel = 1'b0;
      ap(HTRANS_NONSEQ, 16'h0010, 1'b1, HSIZE_WORD);
      tick();
      chk("nosel_rdy", ready0, 1);
      hwdata = 32'h0;
      sel = 1'b1;
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      tick();

      err_case("misalign", 16'h0011, HSIZE_HWORD);
      err_case("size3", 16'h0010, HSIZE_DWORD);
      err_case("range", 16'h0400, HSIZE_WORD);

      ap(HTRANS_NONSEQ, 16'h0010, 1'b0, HSIZE_WORD);
      tick();
      chk("unchanged", rdata0, 32'hA5AD_BEEF);
      ap(HTRANS_NONSEQ, 16'h0010, 1'b1, HSIZE_HWORD);
      tick();
      hwdata = 32'h5555_1234;
      ap(HTRANS_NONSEQ, 16'h0010, 1'b0, HSIZE_WORD);
      tick();
      chk("hword_rd", rdata0, 32'hA5AD_1234);

      // INCR4 burst with a BUSY after beat 2
      hburst = 3'b011;
      ap(HTRANS_NONSEQ, 16'h0020, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'd1;
      ap(HTRANS_SEQ, 16'h0024, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'd2;
      ap(HTRANS_BUSY, 16'h0028, 1'b1, HSIZE_WORD);
      tick();
      chk("busy_rdy", ready0, 1);
      chk("busy_resp", resp0, 0);
      hwdata = 32'hBAD0_BAD0;
      ap(HTRANS_SEQ, 16'h0028, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'd3;
      ap(HTRANS_SEQ, 16'h002C, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'd4;
      ap(HTRANS_NONSEQ, 16'h0020, 1'b0, HSIZE_WORD);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("burst_rd%0d", i), rdata0, 32'(i + 1));
         if (i < 3) ap(HTRANS_SEQ, 16'(16'h0024 + 4 * i), 1'b0, HSIZE_WORD);
         else ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      end
      hburst = 3'b000;
      tick();

      // three wait states
      use3 = 1'b1;
      ap(HTRANS_NONSEQ, 16'h0008, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'hCAFE_F00D;
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      count_waits(n);
      chk("ws3_w_waits", n, 3);
      tick();
      ap(HTRANS_NONSEQ, 16'h0008, 1'b0, HSIZE_WORD);
      tick();
      chk("ws3_wait_rdata", rdata3, 0);
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      count_waits(n);
      chk("ws3_r_waits", n, 3);
      chk("ws3_r_resp", resp3, 0);
      chk("ws3_r_data", rdata3, 32'hCAFE_F00D);
      tick();

      // reset in the middle of a waited write
      ap(HTRANS_NONSEQ, 16'h0008, 1'b1, HSIZE_WORD);
      tick();
      hwdata = 32'h1234_5678;
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      tick();
      hreset = 1'b1;
      #1;
      chk("mrst_rdy", ready3, 1);
      chk("mrst_resp", resp3, 0);
      chk("mrst_rdata", rdata3, 0);
      tick();
      hreset = 1'b0;
      repeat (3) tick();
      ap(HTRANS_NONSEQ, 16'h0008, 1'b0, HSIZE_WORD);
      tick();
      ap(HTRANS_IDLE, 16'h0, 1'b0, HSIZE_WORD);
      count_waits(n);
      chk("mrst_waits", n, 3);
      chk("mrst_nowrite", rdata3, 32'hCAFE_F00D);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
